// File: rtl/switch_nport_fifo.sv
// switch_nport_fifo: 1xN byte-stream packet switch. Packets are routed on their first byte (DA)
// into per-port output FIFOs. Admission is decided for the whole packet when DA arrives. Stored
// length is capped at MAX_PKT. A small register file holds the port and broadcast addresses and
// the drop/truncation counters.
module switch_nport_fifo #(
    parameter int NUM_PORTS  = 4,
    parameter int DW         = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_PKT    = 16,
    parameter int ADDR_W     = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    data_status,
    input  logic [DW-1:0]           data,
    output logic [NUM_PORTS*DW-1:0] port_data,
    output logic [NUM_PORTS-1:0]    ready,
    input  logic [NUM_PORTS-1:0]    read,
    input  logic                    mem_en,
    input  logic                    mem_rd_wr,
    input  logic [ADDR_W-1:0]       mem_add,
    input  logic [DW-1:0]           mem_data,
    output logic [DW-1:0]           mem_rdata
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BC_W  = $clog2(MAX_PKT + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, FWD = 2'd1, DROP = 2'd2} state_t;

    state_t               state_q, state_d;
    logic                 ds_q, ds_d;
    logic [NUM_PORTS-1:0] tgt_q, tgt_d;
    logic [BC_W-1:0]      bcnt_q, bcnt_d;
    logic [DW-1:0]        drop_cnt_q, drop_cnt_d;
    logic [DW-1:0]        trunc_cnt_q, trunc_cnt_d;
    logic [DW-1:0]        port_addr_q [NUM_PORTS];
    logic [DW-1:0]        port_addr_d [NUM_PORTS];
    logic [DW-1:0]        bcast_addr_q, bcast_addr_d;
    logic [DW-1:0]        mem_rdata_q, mem_rdata_d;
    logic [PTR_W-1:0]     wr_ptr_q [NUM_PORTS];
    logic [PTR_W-1:0]     wr_ptr_d [NUM_PORTS];
    logic [PTR_W-1:0]     rd_ptr_q [NUM_PORTS];
    logic [PTR_W-1:0]     rd_ptr_d [NUM_PORTS];
    logic [CNT_W-1:0]     cnt_q [NUM_PORTS];
    logic [CNT_W-1:0]     cnt_d [NUM_PORTS];
    logic [DW-1:0]        pdata_q [NUM_PORTS];
    logic [DW-1:0]        pdata_d [NUM_PORTS];
    logic [DW-1:0]        fifo_mem [NUM_PORTS][FIFO_DEPTH];

    logic                 start;
    logic [NUM_PORTS-1:0] match;
    logic                 room_ok;
    logic                 accept;
    logic [NUM_PORTS-1:0] wr_en;
    logic [NUM_PORTS-1:0] push;
    logic [NUM_PORTS-1:0] pop;
    logic                 drop_inc;
    logic                 trunc_inc;

    // Packet-start detection and DA decode: which ports match and whether all of them have room
    always_comb begin
        start   = data_status & ~ds_q;
        ds_d    = data_status;
        match   = '0;
        room_ok = 1'b1;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (data == port_addr_q[i] || data == bcast_addr_q) match[i] = 1'b1;
            if (match[i] && (FIFO_DEPTH - int'(cnt_q[i])) < MAX_PKT) room_ok = 1'b0;
        end
        accept = (match != '0) && room_ok;
    end

    // Rx FSM state register; ds_q resets high so a packet already in flight is ignored
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ds_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            ds_q    <= ds_d;
        end
    end

    // Rx FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (!accept || MAX_PKT == 1) state_d = DROP;
                    else                         state_d = FWD;
                end
            end
            FWD: begin
                if (!data_status)                        state_d = IDLE;
                else if (bcnt_q == BC_W'(MAX_PKT - 1))   state_d = DROP;
            end
            DROP: begin
                if (!data_status) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Rx FSM outputs: FIFO write enables, latched target set, stored-byte count, counter events
    always_comb begin
        wr_en     = '0;
        tgt_d     = tgt_q;
        bcnt_d    = bcnt_q;
        drop_inc  = 1'b0;
        trunc_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (!accept) begin
                        drop_inc = 1'b1;
                    end else begin
                        wr_en  = match;
                        tgt_d  = match;
                        bcnt_d = BC_W'(1);
                        if (MAX_PKT == 1) trunc_inc = 1'b1;
                    end
                end
            end
            FWD: begin
                if (data_status) begin
                    wr_en  = tgt_q;
                    bcnt_d = bcnt_q + BC_W'(1);
                    if (bcnt_q == BC_W'(MAX_PKT - 1)) trunc_inc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Config register file: address writes, counter updates (clear beats increment), readback
    always_comb begin
        port_addr_d  = port_addr_q;
        bcast_addr_d = bcast_addr_q;
        drop_cnt_d   = drop_cnt_q;
        trunc_cnt_d  = trunc_cnt_q;
        mem_rdata_d  = mem_rdata_q;
        if (drop_inc && drop_cnt_q != '1)   drop_cnt_d  = drop_cnt_q + DW'(1);
        if (trunc_inc && trunc_cnt_q != '1) trunc_cnt_d = trunc_cnt_q + DW'(1);
        if (mem_en && mem_rd_wr) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (mem_add == ADDR_W'(i)) port_addr_d[i] = mem_data;
            end
            if (mem_add == ADDR_W'(NUM_PORTS))     bcast_addr_d = mem_data;
            if (mem_add == ADDR_W'(NUM_PORTS + 1)) drop_cnt_d   = '0;
            if (mem_add == ADDR_W'(NUM_PORTS + 2)) trunc_cnt_d  = '0;
        end
        if (mem_en && !mem_rd_wr) begin
            mem_rdata_d = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (mem_add == ADDR_W'(i)) mem_rdata_d = port_addr_q[i];
            end
            if (mem_add == ADDR_W'(NUM_PORTS))     mem_rdata_d = bcast_addr_q;
            if (mem_add == ADDR_W'(NUM_PORTS + 1)) mem_rdata_d = drop_cnt_q;
            if (mem_add == ADDR_W'(NUM_PORTS + 2)) mem_rdata_d = trunc_cnt_q;
        end
    end

    // Per-port FIFO pointer/count bookkeeping and registered pop data
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            pop[i]      = read[i] && (cnt_q[i] != '0);
            push[i]     = wr_en[i] && ((cnt_q[i] != CNT_W'(FIFO_DEPTH)) || pop[i]);
            wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(pop[i]);
            cnt_d[i]    = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            pdata_d[i]  = pop[i] ? fifo_mem[i][rd_ptr_q[i]] : pdata_q[i];
        end
    end

    // Control, config and FIFO state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tgt_q        <= '0;
            bcnt_q       <= '0;
            drop_cnt_q   <= '0;
            trunc_cnt_q  <= '0;
            bcast_addr_q <= '1;
            mem_rdata_q  <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                port_addr_q[i] <= DW'(i);
                wr_ptr_q[i]    <= '0;
                rd_ptr_q[i]    <= '0;
                cnt_q[i]       <= '0;
                pdata_q[i]     <= '0;
            end
        end else begin
            tgt_q        <= tgt_d;
            bcnt_q       <= bcnt_d;
            drop_cnt_q   <= drop_cnt_d;
            trunc_cnt_q  <= trunc_cnt_d;
            bcast_addr_q <= bcast_addr_d;
            mem_rdata_q  <= mem_rdata_d;
            for (int i = 0; i < NUM_PORTS; i++) begin
                port_addr_q[i] <= port_addr_d[i];
                wr_ptr_q[i]    <= wr_ptr_d[i];
                rd_ptr_q[i]    <= rd_ptr_d[i];
                cnt_q[i]       <= cnt_d[i];
                pdata_q[i]     <= pdata_d[i];
            end
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (push[i]) fifo_mem[i][wr_ptr_q[i]] <= data;
        end
    end

    // Output mapping
    always_comb begin
        port_data = '0;
        ready     = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            port_data[i*DW +: DW] = pdata_q[i];
            ready[i]              = (cnt_q[i] != '0);
        end
        mem_rdata = mem_rdata_q;
    end

endmodule

// File: tb/tb_switch_nport_fifo.sv
// Testbench for switch_nport_fifo: config table, packet routing table, directed corner sequences
// and a randomized phase checked against a queue-based packet model.
`timescale 1ns/1ps
module tb_switch_nport_fifo;
    localparam int NP = 4;
    localparam int DW = 8;
    localparam int FD = 16;
    localparam int MP = 16;
    localparam int AW = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            data_status = 1'b0;
    logic [DW-1:0]   data = '0;
    logic [NP*DW-1:0] port_data;
    logic [NP-1:0]   ready;
    logic [NP-1:0]   read = '0;
    logic            mem_en = 1'b0;
    logic            mem_rd_wr = 1'b0;
    logic [AW-1:0]   mem_add = '0;
    logic [DW-1:0]   mem_data = '0;
    logic [DW-1:0]   mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [7:0] pkt_q[$];
    logic [7:0] mq[NP][$];
    logic [7:0] m_addr[NP];
    logic [7:0] m_bcast;
    logic [7:0] m_drop;
    logic [7:0] m_trunc;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } cfg_vec_t;

    typedef struct {
        logic [7:0] da;
        int         len;
        logic [3:0] exp_ready;
        logic [7:0] exp_drop;
    } pkt_vec_t;

    cfg_vec_t cv[14];
    pkt_vec_t pv[6];

    always #5 clk = ~clk;

    switch_nport_fifo #(.NUM_PORTS(NP), .DW(DW), .FIFO_DEPTH(FD), .MAX_PKT(MP), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .data_status(data_status), .data(data),
        .port_data(port_data), .ready(ready), .read(read),
        .mem_en(mem_en), .mem_rd_wr(mem_rd_wr), .mem_add(mem_add),
        .mem_data(mem_data), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input logic [7:0] a, input logic [7:0] d);
        mem_en = 1'b1; mem_rd_wr = 1'b1; mem_add = a; mem_data = d;
        tick();
        mem_en = 1'b0; mem_rd_wr = 1'b0;
    endtask

    task automatic cfg_rd(input logic [7:0] a, output logic [7:0] v);
        mem_en = 1'b1; mem_rd_wr = 1'b0; mem_add = a;
        tick();
        mem_en = 1'b0;
        v = mem_rdata;
    endtask

    task automatic send_pkt();
        for (int k = 0; k < pkt_q.size(); k++) begin
            data_status = 1'b1; data = pkt_q[k];
            tick();
        end
        data_status = 1'b0; data = '0;
        tick();
    endtask

    task automatic pop(input int p, output logic [7:0] v);
        read = '0; read[p] = 1'b1;
        tick();
        read = '0;
        v = port_data[p*DW +: DW];
    endtask

    task automatic drain_expect(input int p, input int n, input string nm);
        logic [7:0] v;
        for (int k = 0; k < n; k++) begin
            pop(p, v);
            chk(nm, v, pkt_q[k]);
        end
    endtask

    task automatic model_pkt();
        logic [NP-1:0] tg;
        bit ok;
        int n;
        tg = '0;
        for (int i = 0; i < NP; i++) if (pkt_q[0] == m_addr[i]) tg[i] = 1'b1;
        if (pkt_q[0] == m_bcast) tg = '1;
        ok = (tg != '0);
        for (int i = 0; i < NP; i++) if (tg[i] && (FD - mq[i].size()) < MP) ok = 0;
        if (!ok) begin
            if (m_drop != 8'hFF) m_drop++;
        end else begin
            n = (pkt_q.size() < MP) ? pkt_q.size() : MP;
            for (int i = 0; i < NP; i++)
                if (tg[i]) for (int k = 0; k < n; k++) mq[i].push_back(pkt_q[k]);
            if (pkt_q.size() >= MP && m_trunc != 8'hFF) m_trunc++;
        end
    endtask

    function automatic logic [NP-1:0] model_ready();
        logic [NP-1:0] r;
        r = '0;
        for (int i = 0; i < NP; i++) r[i] = (mq[i].size() != 0);
        return r;
    endfunction

    initial begin
        logic [7:0] v;
        logic [7:0] held;
        logic [7:0] addr_pool[3];
        logic [7:0] da_pool[5];
        int len;

        cv[0]  = '{1'b1, 8'd0, 8'h10, 8'h00};
        cv[1]  = '{1'b1, 8'd1, 8'h20, 8'h00};
        cv[2]  = '{1'b1, 8'd2, 8'h30, 8'h00};
        cv[3]  = '{1'b1, 8'd3, 8'h40, 8'h00};
        cv[4]  = '{1'b0, 8'd0, 8'h00, 8'h10};
        cv[5]  = '{1'b0, 8'd1, 8'h00, 8'h20};
        cv[6]  = '{1'b0, 8'd2, 8'h00, 8'h30};
        cv[7]  = '{1'b0, 8'd3, 8'h00, 8'h40};
        cv[8]  = '{1'b0, 8'd4, 8'h00, 8'hFF};
        cv[9]  = '{1'b0, 8'd5, 8'h00, 8'h00};
        cv[10] = '{1'b0, 8'd6, 8'h00, 8'h00};
        cv[11] = '{1'b1, 8'd9, 8'h5A, 8'h00};
        cv[12] = '{1'b0, 8'd9, 8'h00, 8'h00};
        cv[13] = '{1'b0, 8'd7, 8'h00, 8'h00};

        pv[0] = '{8'h40, 3, 4'b1000, 8'd0};
        pv[1] = '{8'h10, 2, 4'b0001, 8'd0};
        pv[2] = '{8'h77, 3, 4'b0000, 8'd1};
        pv[3] = '{8'h30, 5, 4'b0100, 8'd1};
        pv[4] = '{8'hFF, 2, 4'b1111, 8'd1};
        pv[5] = '{8'h66, 1, 4'b0000, 8'd2};

        // Reset state
        tick(); tick();
        chk("rst_ready", ready, 4'b0000);
        chk("rst_port_data", port_data, 32'h0);
        chk("rst_mem_rdata", mem_rdata, 8'h00);
        reset = 1'b1;
        tick();

        // Config write/readback table
        for (int i = 0; i < 14; i++) begin
            if (cv[i].wr) begin
                cfg_wr(cv[i].addr, cv[i].wdata);
            end else begin
                cfg_rd(cv[i].addr, v);
                chk($sformatf("cfg_rd_%0d", i), v, cv[i].exp);
            end
        end
        chk("cfg_ready", ready, 4'b0000);

        // Unicast to port 1
        pkt_q = '{8'h20, 8'hAA, 8'h03, 8'h01, 8'h02, 8'h03};
        send_pkt();
        chk("uni_ready", ready, 4'b0010);
        drain_expect(1, 6, "uni_byte");
        chk("uni_ready_end", ready, 4'b0000);

        // Broadcast then unknown DA
        pkt_q = '{8'hFF, 8'h11, 8'h22, 8'h33};
        send_pkt();
        chk("bc_ready", ready, 4'b1111);
        for (int p = 0; p < NP; p++) drain_expect(p, 4, $sformatf("bc_byte_p%0d", p));
        chk("bc_ready_end", ready, 4'b0000);
        pkt_q = '{8'h55, 8'h01, 8'h02};
        send_pkt();
        chk("unk_ready", ready, 4'b0000);
        cfg_rd(8'd5, v);
        chk("unk_drop_cnt", v, 8'd1);

        // Admission control: port 0 holding 10 bytes cannot accept another packet
        pkt_q = '{8'h10, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87, 8'h88, 8'h89};
        send_pkt();
        pkt_q = '{8'h10, 8'hEE, 8'hEF};
        send_pkt();
        cfg_rd(8'd5, v);
        chk("adm_drop_cnt", v, 8'd2);
        chk("adm_ready", ready, 4'b0001);
        pkt_q = '{8'h10, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87, 8'h88, 8'h89};
        drain_expect(0, 10, "adm_byte");
        chk("adm_ready_end", ready, 4'b0000);

        // Truncation of a 20-byte packet to port 2
        pkt_q.delete();
        pkt_q.push_back(8'h30);
        for (int k = 1; k < 20; k++) pkt_q.push_back(8'(k));
        send_pkt();
        cfg_rd(8'd6, v);
        chk("trunc_cnt", v, 8'd1);
        drain_expect(2, 16, "trunc_byte");
        chk("trunc_ready_end", ready, 4'b0000);
        cfg_wr(8'd6, 8'h00);
        cfg_rd(8'd6, v);
        chk("trunc_clear", v, 8'd0);

        // Packet routing table
        cfg_wr(8'd5, 8'h00);
        for (int i = 0; i < 6; i++) begin
            pkt_q.delete();
            pkt_q.push_back(pv[i].da);
            for (int k = 1; k < pv[i].len; k++) pkt_q.push_back(8'(8'h50 + i * 8 + k));
            send_pkt();
            chk($sformatf("tbl_ready_%0d", i), ready, pv[i].exp_ready);
            for (int p = 0; p < NP; p++)
                if (pv[i].exp_ready[p]) drain_expect(p, pv[i].len, $sformatf("tbl_byte_%0d_p%0d", i, p));
            chk($sformatf("tbl_ready_end_%0d", i), ready, 4'b0000);
            cfg_rd(8'd5, v);
            chk($sformatf("tbl_drop_%0d", i), v, pv[i].exp_drop);
        end

        // Read while empty is ignored
        held = port_data[3*DW +: DW];
        pop(3, v);
        chk("empty_rd_data", v, held);
        chk("empty_rd_ready", ready, 4'b0000);
        pkt_q = '{8'h40, 8'h9A};
        send_pkt();
        drain_expect(3, 2, "empty_rd_next");
        chk("empty_rd_ready_end", ready, 4'b0000);

        // Simultaneous write and pop on port 1
        data_status = 1'b1; data = 8'h20;
        tick();
        for (int k = 1; k <= 4; k++) begin
            data = 8'(8'hC0 + k); read = 4'b0010;
            tick();
            chk($sformatf("wp_data_%0d", k), port_data[1*DW +: DW], (k == 1) ? 8'h20 : 8'(8'hC0 + k - 1));
            chk($sformatf("wp_ready_%0d", k), ready, 4'b0010);
        end
        read = '0; data_status = 1'b0;
        tick();
        pop(1, v);
        chk("wp_last", v, 8'hC4);
        chk("wp_ready_end", ready, 4'b0000);

        // Counter clear coincident with a drop: clear wins
        data_status = 1'b1; data = 8'h55;
        mem_en = 1'b1; mem_rd_wr = 1'b1; mem_add = 8'd5; mem_data = 8'h00;
        tick();
        mem_en = 1'b0; mem_rd_wr = 1'b0; data = 8'h01;
        tick();
        data_status = 1'b0;
        tick();
        cfg_rd(8'd5, v);
        chk("clr_vs_inc", v, 8'd0);

        // Reset in the middle of a packet with data_status held high
        data_status = 1'b1; data = 8'h10;
        tick();
        data = 8'h11;
        tick();
        reset = 1'b0; data = 8'h12;
        #1;
        chk("mid_rst_ready", ready, 4'b0000);
        chk("mid_rst_port_data", port_data, 32'h0);
        chk("mid_rst_mem_rdata", mem_rdata, 8'h00);
        tick();
        reset = 1'b1; data = 8'h02;
        tick();
        data = 8'h03;
        tick();
        chk("mid_rst_ignored", ready, 4'b0000);
        data_status = 1'b0;
        tick();
        cfg_rd(8'd5, v);
        chk("mid_rst_drop", v, 8'd0);
        cfg_rd(8'd0, v);
        chk("mid_rst_addr0", v, 8'd0);
        pkt_q = '{8'h02, 8'hB1, 8'hB2};
        send_pkt();
        chk("post_rst_ready", ready, 4'b0100);
        drain_expect(2, 3, "post_rst_byte");

        // Randomized packets against the queue model
        addr_pool = '{8'h10, 8'h20, 8'h30};
        da_pool   = '{8'h10, 8'h20, 8'h30, 8'hF0, 8'h99};
        for (int i = 0; i < NP; i++) begin
            m_addr[i] = addr_pool[i % 3];
            cfg_wr(8'(i), m_addr[i]);
            mq[i].delete();
        end
        m_bcast = 8'hF0;
        cfg_wr(8'd4, m_bcast);
        m_drop = 8'd0; m_trunc = 8'd0;
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 4) == 0) begin
                int j;
                j = $urandom_range(0, NP - 1);
                m_addr[j] = addr_pool[$urandom_range(0, 2)];
                cfg_wr(8'(j), m_addr[j]);
            end
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(17, 22) : $urandom_range(1, 15);
            pkt_q.delete();
            pkt_q.push_back(da_pool[$urandom_range(0, 4)]);
            for (int k = 1; k < len; k++) pkt_q.push_back(8'($urandom_range(0, 255)));
            model_pkt();
            send_pkt();
            chk($sformatf("rnd_ready_%0d", it), ready, model_ready());
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 1) == 1) begin
                    while (mq[p].size() > 0) begin
                        pop(p, v);
                        chk($sformatf("rnd_byte_%0d_p%0d", it, p), v, mq[p].pop_front());
                    end
                end
            end
            chk($sformatf("rnd_ready_drain_%0d", it), ready, model_ready());
            cfg_rd(8'd5, v);
            chk($sformatf("rnd_drop_%0d", it), v, m_drop);
            cfg_rd(8'd6, v);
            chk($sformatf("rnd_trunc_%0d", it), v, m_trunc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
